// File: rtl/pipe_sched_ctrl.sv
// Pipeline scheduler: stall vector merge, branch/exception redirect,
// stall-cycle counter and stuck-stall watchdog.
module pipe_sched_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             stallreq_if_i,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    input  logic             branch_flag_i,
    input  logic [31:0]      branch_target_i,
    input  logic             excp_i,
    input  logic             cnt_clr_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic             redirect_flag_o,
    output logic [31:0]      redirect_addr_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic             wdog_o
);

    localparam int unsigned RUN_W = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_HOLD,
        S_FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             wdog_q, wdog_d;
    logic [5:0]       stall_req;
    logic [5:0]       stall;
    logic             stall_any;

    // Fixed-priority stall merge; the deepest stalled stage freezes all older ones
    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_mem_i)
            stall_req = 6'b011111;
        else if (stallreq_ex_i)
            stall_req = 6'b001111;
        else if (stallreq_id_i)
            stall_req = 6'b000111;
        else if (stallreq_if_i)
            stall_req = 6'b000011;
        stall     = (state_q == S_FLUSH) ? 6'b000000 : stall_req;
        stall_any = |stall;
    end

    // State and debug counters
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= S_RUN;
            pend_addr_q <= 32'h0;
            cnt_q       <= '0;
            run_q       <= '0;
            wdog_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            cnt_q       <= cnt_d;
            run_q       <= run_d;
            wdog_q      <= wdog_d;
        end
    end

    // Next state; an exception overrides any branch or pending redirect
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        unique case (state_q)
            S_RUN: begin
                if (excp_i) begin
                    state_d = S_FLUSH;
                end else if (branch_flag_i && stall[0]) begin
                    state_d     = S_HOLD;
                    pend_addr_d = branch_target_i;
                end
            end
            S_HOLD: begin
                if (excp_i)
                    state_d = S_FLUSH;
                else if (!stall[0])
                    state_d = S_RUN;
            end
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Saturating stall counter and consecutive-stall run length
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i)
            cnt_d = '0;
        else if (stall_any && !(&cnt_q))
            cnt_d = cnt_q + CNT_W'(1);
        run_d = '0;
        if (stall_any)
            run_d = (run_q == RUN_W'(WDOG_LIMIT)) ? run_q : run_q + RUN_W'(1);
        wdog_d = wdog_q | (run_d == RUN_W'(WDOG_LIMIT));
    end

    // Outputs; everything is held quiet while reset is asserted
    always_comb begin
        stall_o         = 6'b000000;
        flush_o         = 1'b0;
        redirect_flag_o = 1'b0;
        redirect_addr_o = 32'h0;
        if (clr_n) begin
            stall_o = stall;
            unique case (state_q)
                S_RUN: begin
                    if (branch_flag_i && !stall[0] && !excp_i) begin
                        redirect_flag_o = 1'b1;
                        redirect_addr_o = branch_target_i;
                    end
                end
                S_HOLD: begin
                    redirect_flag_o = 1'b1;
                    redirect_addr_o = pend_addr_q;
                end
                S_FLUSH: begin
                    flush_o         = 1'b1;
                    redirect_flag_o = 1'b1;
                    redirect_addr_o = EXC_VECTOR;
                end
                default: ;
            endcase
        end
    end

    assign stall_cycles_o = cnt_q;
    assign wdog_o         = wdog_q;

endmodule
